serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It accepts two WIDTH-bit operands with a start pulse and sequences a single 1-bit `fa` full-adder cell LSB-first over WIDTH clock cycles. A carry flop feeds each bit's carry back into the next. It presents a registered WIDTH-bit sum and carry-out with a one-cycle done strobe. It is the area-minimal alternative to the ripple-carry adder for slow-path arithmetic in the datapath.

---
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic [WIDTH-1:0] s_next;
   logic [CW-1:0]    count;
   logic             c;
   logic             fa_b;
   logic             fa_sum;
   logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q;
   // Subtract as a + ~b + 1; the +1 comes from the preset carry.
   assign fa_b = b_sh[0] ^ sub_q;
`else
   assign fa_b = b_sh[0];
`endif

   fa u_fa (
      .a    (a_sh[0]),
      .b    (fa_b),
      .cin  (c),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
   if (WIDTH == 1) begin : g_s_one
      assign s_next = fa_sum;
   end else begin : g_s_many
      assign s_next = {fa_sum, s_sh[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         c     <= 1'b0;
         count <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_RUN: begin
               c     <= fa_cout;
               s_sh  <= s_next;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               count <= count + CW'(1);
               if (count == LAST) begin
                  sum   <= s_next;
                  cout  <= fa_cout;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
            default: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  count <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                  sub_q <= sub;
                  c     <= sub ? 1'b1 : cin;
`else
                  c     <= cin;
`endif
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH = 8); subtract cases need SERIAL_ADDER_SUB_EN.

module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         cin_i;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub_i;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;
   logic [W:0] exp_q[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .cin   (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub_i),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done strobe must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         logic [W:0] e;
         done_cnt      = done_cnt + 1;
         prev_done_cyc = last_done_cyc;
         last_done_cyc = cyc;
         checks        = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_done: got {cout,sum}=%h with nothing expected", {cout, sum});
         end else begin
            e = exp_q.pop_front();
            if ({cout, sum} !== e) begin
               errors = errors + 1;
               $display("FAIL result: got {cout,sum}=%h expected %h", {cout, sum}, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Presents one start pulse; returns at the negedge after the accepting edge.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic [W:0] expv, input bit push);
      @(negedge clk);
      a_i   = av;
      b_i   = bv;
      cin_i = ci;
      start = 1'b1;
      if (push) exp_q.push_back(expv);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy) return;
         @(negedge clk);
      end
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL timeout: busy still %0b after %0d cycles", busy, max_cyc);
   endtask

   initial begin
      int n_busy;
      int done_at;
      int d0;
      bit seen;

      rst   = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  32'(sum),  32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;

      // Basic add with busy-length and done-position checks.
      issue(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
      n_busy  = 0;
      done_at = 0;
      for (int i = 0; i < 30; i++) begin
         if (!busy) break;
         n_busy++;
         if (done && done_at == 0) done_at = n_busy;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(n_busy), 32'd9);
      chk("done_cycle",  32'(done_at), 32'd9);

      // Carry ripple and carry-in.
      issue(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
      wait_idle(30);
      issue(8'hFF, 8'h00, 1'b1, 9'h100, 1'b1);
      wait_idle(30);

      // start during RUN is ignored.
      d0 = done_cnt;
      issue(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);
      repeat (2) @(negedge clk);
      a_i   = 8'hAA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(30);
      @(negedge clk);
      chk("ignored_done_count", 32'(done_cnt - d0), 32'd1);
      chk("ignored_idle_busy",  32'(busy), 32'd0);

      // Back-to-back: hold start, swap operands in the DONE cycle.
      d0 = done_cnt;
      @(negedge clk);
      a_i   = 8'h10;
      b_i   = 8'h20;
      cin_i = 1'b0;
      start = 1'b1;
      exp_q.push_back(9'h030);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("b2b_first_done_seen", 32'(seen), 32'd1);
      a_i = 8'h80;
      b_i = 8'h80;
      exp_q.push_back(9'h100);
      @(negedge clk);
      start = 1'b0;
      wait_idle(30);
      chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
      chk("b2b_spacing",    32'(last_done_cyc - prev_done_cyc), 32'd9);

      // Reset at E4 discards the operation in flight.
      d0 = done_cnt;
      issue(8'hF0, 8'h0F, 1'b0, 9'h000, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_sum",  32'(sum),  32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
      sub_i = 1'b1;
      issue(8'h10, 8'h01, 1'b0, 9'h10F, 1'b1);
      wait_idle(30);
      issue(8'h00, 8'h01, 1'b1, 9'h0FF, 1'b1);
      wait_idle(30);
      sub_i = 1'b0;
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
